// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// muldiv_unit
//   Iterative multiply/divide unit holding the architectural HI/LO pair.
//   Multiplies use a radix-2 shift-add over WIDTH cycles; divides use
//   restoring division over WIDTH cycles. Signed operations run on operand
//   magnitudes and fix up signs in a single finishing cycle.
//
// Ports
//   i_clk      clock, all state updates on the rising edge
//   i_rst_n    asynchronous active-low reset
//   i_start    request, accepted only while idle
//   i_op       000 MULT, 001 MULTU, 010 MADD, 011 MSUB,
//              100 DIV,  101 DIVU,  110 MTHI, 111 MTLO
//   i_a, i_b   operands (rs, rt), sampled on the accept edge
//   i_abort    flush, cancels any operation in flight
//   o_busy     high while an iterative operation is in flight
//   o_done     one-cycle pulse, o_hi/o_lo already hold the result
//   o_divzero  pulses with o_done when a divide had i_b == 0
//   o_hi, o_lo architectural HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_divzero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // Magnitude of a two's-complement value; the most-negative value maps to
    // 2^(WIDTH-1), which is exactly right when read as unsigned.
    function automatic logic [WIDTH-1:0] f_abs(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] u;
        u = v;
        return v[WIDTH-1] ? -u : u;
    endfunction

    function automatic logic [WIDTH-1:0] f_sign_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_sign_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_t               r_state;
    logic [CNTW-1:0]      r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_divzero;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic [2:0]           r_op;
    logic                 r_dz;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [WIDTH-1:0]     r_opnd;
    logic [2*WIDTH-1:0]   r_acc;

    logic                 w_accept;
    logic                 w_iter;
    logic                 w_signed;
    logic signed [WIDTH-1:0] w_a_s;
    logic signed [WIDTH-1:0] w_b_s;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_shift;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_diff;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_hilo;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [2*WIDTH-1:0]   w_res;

    assign w_accept = (r_state == S_IDLE) && i_start && !i_abort;
    assign w_iter   = (i_op[2:1] != 2'b11);
    // Only MULTU (001) and DIVU (101) are unsigned.
    assign w_signed = i_op[1] | ~i_op[0];
    assign w_a_s    = i_a;
    assign w_b_s    = i_b;
    assign w_a_mag  = w_signed ? f_abs(w_a_s) : i_a;
    assign w_b_mag  = w_signed ? f_abs(w_b_s) : i_b;

    // Shift-add step: accumulator is {partial sum, remaining multiplier bits}.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

    // Restoring step: accumulator is {partial remainder, remaining dividend bits}.
    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;

    // Finishing stage: sign fix-up and accumulate against the live HI/LO.
    assign w_prod = f_sign_2w(r_acc, r_neg_q);
    assign w_hilo = {r_hi, r_lo};
    assign w_quo  = r_dz ? '1 : f_sign_w(r_acc[WIDTH-1:0], r_neg_q);
    assign w_rem  = f_sign_w(r_acc[2*WIDTH-1:WIDTH], r_neg_r);

    always_comb begin
        w_res = w_prod;
        case (r_op)
            3'b010:         w_res = w_hilo + w_prod;
            3'b011:         w_res = w_hilo - w_prod;
            3'b100, 3'b101: w_res = {w_rem, w_quo};
            default:        w_res = w_prod;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_iter) begin
                            r_state <= i_op[2] ? S_DIV : S_MUL;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            if (i_op[0]) r_lo <= i_a;
                            else         r_hi <= i_a;
                            r_done <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNTW'(WIDTH - 1)) begin
                        r_state <= S_FIN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!i_abort) begin
                        {r_hi, r_lo} <= w_res;
                        r_done       <= 1'b1;
                        r_divzero    <= r_dz & r_op[2];
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture and iteration datapath (no reset, control gates use).
    always_ff @(posedge i_clk) begin
        if (w_accept && w_iter) begin
            r_op    <= i_op;
            r_dz    <= ~|i_b;
            r_neg_q <= w_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r <= w_signed & i_a[WIDTH-1];
            if (i_op[2]) begin
                r_opnd <= w_b_mag;
                r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
            end else begin
                r_opnd <= w_a_mag;
                r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
            end
        end else if (r_state == S_MUL) begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
        end else if (r_state == S_DIV) begin
            if (w_div_ge) r_acc <= {w_div_diff, r_acc[WIDTH-2:0], 1'b1};
            else          r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_divzero = r_divzero;
    assign o_hi      = r_hi;
    assign o_lo      = r_lo;

endmodule
